// File: rtl/dispatch_pkg.sv
// Shared definitions for the request dispatcher: opcode encoding, slot states
// and the bit positions of the fields inside a packed instruction.
package dispatch_pkg;

  localparam logic [1:0] OP_AES_ENC = 2'b00;
  localparam logic [1:0] OP_AES_DEC = 2'b01;
  localparam logic [1:0] OP_SHA     = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY
  } slot_state_t;

  // Packed instruction is {opcode, key_addr, text_addr}, text in the LSBs.
  localparam int unsigned TEXT_LSB = 0;

  function automatic int unsigned key_lsb(input int unsigned addrw);
    return addrw;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned addrw);
    return 2 * addrw;
  endfunction

endpackage

// File: rtl/engine_slot.sv
// One engine slot: IDLE/ISSUE/BUSY handshake FSM plus the latched job payload.
// The job counter port exists only when REQ_DISPATCH_STATS_EN is defined.
module engine_slot
  import dispatch_pkg::*;
#(
  parameter int unsigned PayloadW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PayloadW-1:0] payload_in,
  output logic                slot_ready,
  output logic                eng_valid,
  input  logic                eng_ready,
  input  logic                eng_done,
  output logic [PayloadW-1:0] payload
`ifdef REQ_DISPATCH_STATS_EN
  ,
  output logic [15:0]         jobs
`endif
);

  slot_state_t         state_q, state_d;
  logic [PayloadW-1:0] payload_q, payload_d;
  logic                accept;

  assign accept = start && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = ISSUE;
          payload_d = payload_in;
        end
      end
      ISSUE: begin
        // done is ignored here; only the engine handshake advances the slot
        if (eng_ready) state_d = BUSY;
      end
      BUSY: begin
        if (eng_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
    end
  end

  assign slot_ready = (state_q == IDLE);
  assign eng_valid  = (state_q == ISSUE);
  assign payload    = payload_q;

`ifdef REQ_DISPATCH_STATS_EN
  logic [15:0] jobs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jobs_q <= '0;
    end else if ((state_q == BUSY) && eng_done) begin
      jobs_q <= jobs_q + 16'd1;
    end
  end

  assign jobs = jobs_q;
`endif

endmodule

// File: rtl/req_dispatch.sv
// Decodes queued instructions and hands them to independent AES and SHA slots.
// Define REQ_DISPATCH_STATS_EN to add the per-engine completed-job counters.
module req_dispatch
  import dispatch_pkg::*;
#(
  parameter int unsigned ADDRW   = 8,
  parameter int unsigned OPCODEW = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2*ADDRW+OPCODEW-1:0] instr,
  input  logic                       valid_in,
  output logic                       ready_aes,
  output logic                       ready_sha,
  output logic                       aes_valid,
  input  logic                       aes_ready,
  output logic                       aes_decrypt,
  output logic [ADDRW-1:0]           aes_key_addr,
  output logic [ADDRW-1:0]           aes_text_addr,
  input  logic                       aes_done,
  output logic                       sha_valid,
  input  logic                       sha_ready,
  output logic [ADDRW-1:0]           sha_text_addr,
  input  logic                       sha_done,
  output logic                       err_illegal
`ifdef REQ_DISPATCH_STATS_EN
  ,
  output logic [15:0]                aes_jobs,
  output logic [15:0]                sha_jobs
`endif
);

  localparam int unsigned OpLsb  = op_lsb(ADDRW);
  localparam int unsigned KeyLsb = key_lsb(ADDRW);
  localparam int unsigned AesW   = 2 * ADDRW + 1;

  logic [OPCODEW-1:0] opcode;
  logic [ADDRW-1:0]   key_field;
  logic [ADDRW-1:0]   text_field;
  logic               route_aes;
  logic               aes_start;
  logic               sha_start;
  logic               err_d, err_q;
  logic [AesW-1:0]    aes_payload_in;
  logic [AesW-1:0]    aes_payload;

  assign opcode     = instr[OpLsb +: OPCODEW];
  assign key_field  = instr[KeyLsb +: ADDRW];
  assign text_field = instr[TEXT_LSB +: ADDRW];

  assign route_aes = (opcode == OP_AES_ENC) || (opcode == OP_AES_DEC);

  // Reserved opcodes are consumed through the SHA ready but never start a job.
  assign aes_start = valid_in && ready_aes && route_aes;
  assign sha_start = valid_in && ready_sha && (opcode == OP_SHA);
  assign err_d     = valid_in && ready_sha && (opcode == OP_RSVD);

  assign aes_payload_in = {(opcode == OP_AES_DEC), key_field, text_field};

  engine_slot #(
    .PayloadW (AesW)
  ) u_aes_slot (
    .clk        (clk),
    .rst        (rst),
    .start      (aes_start),
    .payload_in (aes_payload_in),
    .slot_ready (ready_aes),
    .eng_valid  (aes_valid),
    .eng_ready  (aes_ready),
    .eng_done   (aes_done),
    .payload    (aes_payload)
`ifdef REQ_DISPATCH_STATS_EN
    ,
    .jobs       (aes_jobs)
`endif
  );

  engine_slot #(
    .PayloadW (ADDRW)
  ) u_sha_slot (
    .clk        (clk),
    .rst        (rst),
    .start      (sha_start),
    .payload_in (text_field),
    .slot_ready (ready_sha),
    .eng_valid  (sha_valid),
    .eng_ready  (sha_ready),
    .eng_done   (sha_done),
    .payload    (sha_text_addr)
`ifdef REQ_DISPATCH_STATS_EN
    ,
    .jobs       (sha_jobs)
`endif
  );

  assign aes_decrypt   = aes_payload[AesW-1];
  assign aes_key_addr  = aes_payload[ADDRW +: ADDRW];
  assign aes_text_addr = aes_payload[0 +: ADDRW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_illegal = err_q;

endmodule

// File: tb/tb_req_dispatch.sv
// Directed self-checking bench for req_dispatch; inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_req_dispatch;

  logic        clk;
  logic        rst;
  logic [17:0] instr;
  logic        valid_in;
  logic        ready_aes, ready_sha;
  logic        aes_valid, aes_ready, aes_decrypt, aes_done;
  logic [7:0]  aes_key_addr, aes_text_addr;
  logic        sha_valid, sha_ready, sha_done;
  logic [7:0]  sha_text_addr;
  logic        err_illegal;
`ifdef REQ_DISPATCH_STATS_EN
  logic [15:0] aes_jobs, sha_jobs;
`endif

  int total;
  int bad;

  req_dispatch #(
    .ADDRW   (8),
    .OPCODEW (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .valid_in      (valid_in),
    .ready_aes     (ready_aes),
    .ready_sha     (ready_sha),
    .aes_valid     (aes_valid),
    .aes_ready     (aes_ready),
    .aes_decrypt   (aes_decrypt),
    .aes_key_addr  (aes_key_addr),
    .aes_text_addr (aes_text_addr),
    .aes_done      (aes_done),
    .sha_valid     (sha_valid),
    .sha_ready     (sha_ready),
    .sha_text_addr (sha_text_addr),
    .sha_done      (sha_done),
    .err_illegal   (err_illegal)
`ifdef REQ_DISPATCH_STATS_EN
    ,
    .aes_jobs      (aes_jobs),
    .sha_jobs      (sha_jobs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge.
  task automatic send(input logic [1:0] op, input logic [7:0] key, input logic [7:0] text);
    instr    = {op, key, text};
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  task automatic sha_job(input logic [7:0] text);
    send(2'b10, 8'h00, text);
    sha_ready = 1'b1;
    step();
    sha_ready = 1'b0;
    sha_done  = 1'b1;
    step();
    sha_done  = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    instr     = '0;
    valid_in  = 1'b0;
    aes_ready = 1'b0;
    aes_done  = 1'b0;
    sha_ready = 1'b0;
    sha_done  = 1'b0;
    step();
    step();

    check("rst_ready_aes", ready_aes, 1);
    check("rst_ready_sha", ready_sha, 1);
    check("rst_aes_valid", aes_valid, 0);
    check("rst_sha_valid", sha_valid, 0);
    check("rst_err", err_illegal, 0);
    check("rst_aes_ops", {aes_decrypt, aes_key_addr, aes_text_addr}, 0);
    check("rst_sha_text", sha_text_addr, 0);
    rst = 1'b0;
    step();

    // AES encrypt accepted, then stalled by the engine for 5 cycles.
    send(2'b00, 8'h12, 8'h34);
    check("enc_valid", aes_valid, 1);
    check("enc_decrypt", aes_decrypt, 0);
    check("enc_key", aes_key_addr, 8'h12);
    check("enc_text", aes_text_addr, 8'h34);
    check("enc_ready_aes", ready_aes, 0);
    check("enc_ready_sha", ready_sha, 1);
    for (int i = 0; i < 5; i++) begin
      aes_done = (i == 2);  // spurious done while in ISSUE
      step();
      aes_done = 1'b0;
      check("stall_valid", aes_valid, 1);
      check("stall_ops", {aes_key_addr, aes_text_addr}, 16'h1234);
    end

    aes_ready = 1'b1;
    step();
    aes_ready = 1'b0;
    check("hs_valid_low", aes_valid, 0);
    check("hs_ready_aes", ready_aes, 0);

    // SHA job while AES is busy.
    send(2'b10, 8'h00, 8'h77);
    check("sha_valid", sha_valid, 1);
    check("sha_text", sha_text_addr, 8'h77);
    check("sha_ready_low", ready_sha, 0);
    check("aes_still_busy", ready_aes, 0);
    sha_ready = 1'b1;
    step();
    sha_ready = 1'b0;
    check("sha_hs_valid", sha_valid, 0);
    step();

    aes_done = 1'b1;
    step();
    aes_done = 1'b0;
    check("aes_done_ready", ready_aes, 1);
    check("sha_busy_ready", ready_sha, 0);
    sha_done = 1'b1;
    step();
    sha_done = 1'b0;
    check("sha_done_ready", ready_sha, 1);

    // AES decrypt.
    send(2'b01, 8'hAA, 8'h55);
    check("dec_valid", aes_valid, 1);
    check("dec_decrypt", aes_decrypt, 1);
    check("dec_ops", {aes_key_addr, aes_text_addr}, 16'hAA55);
    // A second AES request while not ready must not disturb the held job.
    send(2'b00, 8'h0F, 8'h0E);
    check("noacc_decrypt", aes_decrypt, 1);
    check("noacc_ops", {aes_key_addr, aes_text_addr}, 16'hAA55);
    aes_ready = 1'b1;
    step();
    aes_ready = 1'b0;
    aes_done  = 1'b1;
    step();
    aes_done  = 1'b0;
    check("dec_idle", ready_aes, 1);

    // Spurious done in IDLE.
    aes_done = 1'b1;
    step();
    aes_done = 1'b0;
    check("idle_done_ready", ready_aes, 1);
    check("idle_done_valid", aes_valid, 0);

    // Reserved opcode: one err pulse, nothing dispatched.
    send(2'b11, 8'h01, 8'h02);
    check("rsvd_err", err_illegal, 1);
    check("rsvd_sha_valid", sha_valid, 0);
    check("rsvd_ready_sha", ready_sha, 1);
    step();
    check("rsvd_err_clear", err_illegal, 0);
    check("rsvd_sha_valid2", sha_valid, 0);

    // Asynchronous reset while AES is in ISSUE.
    send(2'b01, 8'h3C, 8'hC3);
    check("pre_rst_valid", aes_valid, 1);
    rst = 1'b1;
    #1;
    check("arst_valid", aes_valid, 0);
    check("arst_ready", ready_aes, 1);
    check("arst_ops", {aes_decrypt, aes_key_addr, aes_text_addr}, 0);
    step();
    rst = 1'b0;
    step();

`ifdef REQ_DISPATCH_STATS_EN
    check("stats_rst_sha", sha_jobs, 0);
    sha_job(8'h01);
    sha_job(8'h02);
    sha_job(8'h03);
    check("stats_sha", sha_jobs, 3);
    check("stats_aes", aes_jobs, 0);
`else
    sha_job(8'h01);
    check("post_sha_ready", ready_sha, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
